// File: rtl/enc_bundle_seq.sv
// Bundles a hypervector slice by slice: per-dimension popcount of feature bits compared to a latched threshold.
// Latency: hv_valid rises NUM_CHUNKS+1 clock edges after the edge that accepts start.
// Backpressure: the finished vector is held with hv_valid high until hv_ready; start is ignored until back in IDLE.
module enc_bundle_seq #(
    parameter int  FEATURE_COUNT = 32,
    parameter int  HV_DIM        = 5000,
    parameter int  DIMS_PER_CC   = 500,
    localparam int NUM_CHUNKS    = HV_DIM / DIMS_PER_CC,
    localparam int CW            = $clog2(FEATURE_COUNT + 1)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [CW-1:0]                               thr,
    output logic                                        busy,
    output logic [3:0]                                  ctr,
    input  logic [DIMS_PER_CC-1:0][FEATURE_COUNT-1:0]   mux_out,
    output logic [HV_DIM-1:0]                           hv_out,
    output logic                                        hv_valid,
    input  logic                                        hv_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // ctr value that parks the upstream mux on its all-zero default slice
    localparam logic [3:0] CTR_PARK = 4'd15;
    localparam logic [3:0] CTR_LAST = 4'(NUM_CHUNKS - 1);

    state_t                  state;
    logic [CW-1:0]           thr_q;
    logic [DIMS_PER_CC-1:0]  cmp_dat;
    logic                    stage_vld;
    logic [3:0]              stage_idx;
    logic [DIMS_PER_CC-1:0]  stage_dat;
    logic [HV_DIM-1:0]       hv_reg;

    function automatic logic [CW-1:0] popcnt(input logic [FEATURE_COUNT-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < FEATURE_COUNT; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Threshold each dimension of the slice currently returned by the upstream mux
    always_comb begin
        cmp_dat = '0;
        for (int d = 0; d < DIMS_PER_CC; d++) begin
            cmp_dat[d] = (popcnt(mux_out[d]) >= thr_q);
        end
    end

    // Control FSM: chunk sequencing, threshold latch and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ctr      <= CTR_PARK;
            busy     <= 1'b0;
            hv_valid <= 1'b0;
            thr_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        ctr   <= 4'd0;
                        thr_q <= thr;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (ctr == CTR_LAST) begin
                        state <= DRAIN;
                        ctr   <= CTR_PARK;
                    end else begin
                        ctr <= ctr + 4'd1;
                    end
                end
                DRAIN: begin
                    // the last chunk leaves the stage register on this edge
                    state    <= DONE;
                    hv_valid <= 1'b1;
                end
                DONE: begin
                    // a coincident start is deliberately not looked at here
                    if (hv_ready) begin
                        state    <= IDLE;
                        hv_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ctr   <= CTR_PARK;
                end
            endcase
        end
    end

    // Datapath: capture compare results one stage, then commit them into their chunk of hv_reg
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= 1'b0;
            stage_idx <= '0;
            stage_dat <= '0;
            hv_reg    <= '0;
        end else begin
            stage_vld <= (state == RUN);
            if (state == RUN) begin
                stage_idx <= ctr;
                stage_dat <= cmp_dat;
            end
            if (stage_vld) begin
                for (int c = 0; c < NUM_CHUNKS; c++) begin
                    if (stage_idx == 4'(c)) begin
                        hv_reg[c*DIMS_PER_CC +: DIMS_PER_CC] <= stage_dat;
                    end
                end
            end
        end
    end

    assign hv_out = hv_reg;

endmodule

// File: doc/enc_bundle_seq.md
ENC_BUNDLE_SEQ -- requirements
Module: enc_bundle_seq

Interface
REQ-001 SHALL have parameter FEATURE_COUNT, default 32, feature bits bundled per dimension.
REQ-002 SHALL have parameter HV_DIM, default 5000, hypervector dimension.
REQ-003 SHALL have parameter DIMS_PER_CC, default 500, dimensions processed per cycle; NUM_CHUNKS = HV_DIM/DIMS_PER_CC (10).
REQ-004 SHALL derive CW = $clog2(FEATURE_COUNT+1), width of popcount and threshold.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  request to bundle one hypervector; honoured only in IDLE.
REQ-009 thr  input  CW  bundling threshold, latched on accepted start.
REQ-010 busy  output  1  high in RUN, DRAIN, DONE.
REQ-011 ctr  output  4  chunk select driven to the upstream slice mux.
REQ-012 mux_out  input  [FEATURE_COUNT-1:0] x DIMS_PER_CC  slice returned combinationally by the upstream mux for the current ctr.
REQ-013 hv_out  output  HV_DIM  bundled hypervector.
REQ-014 hv_valid  output  1  hv_out complete and stable.
REQ-015 hv_ready  input  1  downstream accepts hv_out.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: ctr = 4'd15 (upstream default yields all-zero slice); start=1 at edge -> RUN, ctr=0, thr latched.
REQ-018 RUN: ctr increments by 1 per edge; edge with ctr==NUM_CHUNKS-1 -> DRAIN, ctr=15.
REQ-019 Per dimension d of slice: bit = (popcount(mux_out[d]) >= thr_latched), unsigned CW-bit compare.
REQ-020 Compare results and chunk index SHALL be registered one stage (stage register, valid bit) on every RUN edge.
REQ-021 Stage register with valid SHALL write hv_reg[idx*DIMS_PER_CC +: DIMS_PER_CC] on next edge; no other slice altered.
REQ-022 DRAIN: one cycle; its exit edge writes chunk NUM_CHUNKS-1 and enters DONE with hv_valid=1.
REQ-023 hv_valid SHALL rise exactly NUM_CHUNKS+1 edges after the start-accepting edge (11 at defaults).
REQ-024 DONE: hv_valid=1, hv_out=hv_reg held stable; edge with hv_ready=1 -> IDLE, hv_valid=0.
REQ-025 hv_out SHALL be driven directly from hv_reg in all states.
REQ-026 start outside IDLE SHALL be ignored (no restart, no thr change).
REQ-027 start=1 coincident with hv_ready=1 in DONE SHALL only complete the handshake; new start accepted from IDLE.
REQ-028 thr=0 SHALL yield all-ones slices; thr > FEATURE_COUNT SHALL yield all-zero slices.
REQ-029 ctr SHALL never present values NUM_CHUNKS..14.
REQ-030 hv_ready in IDLE/RUN/DRAIN SHALL have no effect.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, ctr=15, busy=0, hv_valid=0, hv_reg=0, thr_latched=0, stage valid=0, regardless of state.
REQ-032 Reset mid-RUN SHALL abandon the partial vector; no hv_valid pulse follows.
REQ-033 rst SHALL take priority over start and hv_ready in the same cycle.

Verification
REQ-034 Upstream mux model, all mux_out bits = 1, thr=32, start -> hv_valid after 11 edges, hv_out all ones, ctr sequence 0..9 then 15.
REQ-035 Chunk k dims carry popcount k*3 (k=0..9), thr=15 -> chunks 0..4 zero, chunks 5..9 all ones in hv_out.
REQ-036 thr=0 with all-zero features -> hv_out all ones; thr=33 with all-one features -> hv_out all zeros.
REQ-037 rst asserted while ctr=4 -> next cycle ctr=15, busy=0, hv_out=0, no hv_valid for 20 cycles.
REQ-038 hv_ready held 0 for 5 cycles in DONE, start pulsed meanwhile -> hv_out unchanged, ctr stays 15, IDLE after hv_ready=1.
REQ-039 Back-to-back: hv_ready=1 and start=1 same edge in DONE -> IDLE; start next cycle -> second vector correct with new thr.
